// File: rtl/sound_event_scheduler_pkg.sv
// Shared codes, FSM encodings and default tone constants for the sound event scheduler.
// Also holds the saturating adder used for the lost-request counter.
package sound_event_scheduler_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_HALT  = 2'd1,
    SRC_MATCH = 2'd2,
    SRC_KEY   = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int NUM_SRC = 3;

  localparam logic [17:0] HP_HALT_DEF   = 18'd50000;
  localparam logic [23:0] DUR_HALT_DEF  = 24'd25000000;
  localparam logic [17:0] HP_MATCH_DEF  = 18'd25000;
  localparam logic [23:0] DUR_MATCH_DEF = 24'd10000000;
  localparam logic [17:0] HP_KEY_DEF    = 18'd12500;
  localparam logic [23:0] DUR_KEY_DEF   = 24'd2500000;
  localparam logic [23:0] GAP_DEF       = 24'd2500000;

  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/sound_event_scheduler_req_latch.sv
// One requester: rising-edge detect, pending flag, and a one-cycle strobe for a coalesced edge.
// A new edge beats a same-cycle grant clear; mute flushes the flag and swallows edges.
module sound_event_scheduler_req_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic mute,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic drop
);

  logic req_q;
  logic pend_q;
  logic pend_d;
  logic req_rise;

  assign req_rise = req & ~req_q;

  always_comb begin
    pend_d = pend_q;
    if (mute) begin
      pend_d = 1'b0;
    end else if (req_rise) begin
      pend_d = 1'b1;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req_q  <= req;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
  assign drop = req_rise & pend_q & ~clr & ~mute;

endmodule

// File: rtl/sound_event_scheduler.sv
// Arbitrates halt/match/key requests onto one tone generator: edge->trigger in 2 cycles when idle,
// then holds pitch/length through the tone and a silent gap; requests arriving meanwhile wait.
module sound_event_scheduler
  import sound_event_scheduler_pkg::*;
#(
  parameter logic [17:0] HP_HALT   = HP_HALT_DEF,
  parameter logic [23:0] DUR_HALT  = DUR_HALT_DEF,
  parameter logic [17:0] HP_MATCH  = HP_MATCH_DEF,
  parameter logic [23:0] DUR_MATCH = DUR_MATCH_DEF,
  parameter logic [17:0] HP_KEY    = HP_KEY_DEF,
  parameter logic [23:0] DUR_KEY   = DUR_KEY_DEF,
  parameter logic [23:0] GAP       = GAP_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mute,
  input  logic        req_halt,
  input  logic        req_match,
  input  logic        req_key,
  output logic        play_trigger,
  output logic [17:0] half_period,
  output logic [23:0] duration,
  output logic        busy,
  output logic [1:0]  active_src,
  output logic [7:0]  drop_count
);

  localparam logic [23:0] GAP_M1 = GAP - 24'd1;

  logic [NUM_SRC-1:0] req_vec;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] drop;
  logic [NUM_SRC-1:0] clr;

  assign req_vec = {req_key, req_match, req_halt};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sound_event_scheduler_req_latch u_latch (
      .clk     (clk),
      .reset_n (reset_n),
      .mute    (mute),
      .req     (req_vec[i]),
      .clr     (clr[i]),
      .pend    (pend[i]),
      .drop    (drop[i])
    );
  end

  state_e      state_q;
  src_e        src_q;
  logic [23:0] timer_q;
  logic        trig_q;
  logic        busy_q;
  logic [17:0] hp_q;
  logic [23:0] dur_q;
  logic [7:0]  drop_cnt_q;
  logic [7:0]  drop_cnt_d;

  src_e        grant_src;
  logic [17:0] hp_sel;
  logic [23:0] dur_sel;

  // Fixed priority: halt over match over key, only from IDLE and never while muted.
  always_comb begin
    grant_src = SRC_NONE;
    if (state_q == ST_IDLE && !mute) begin
      if (pend[0]) begin
        grant_src = SRC_HALT;
      end else if (pend[1]) begin
        grant_src = SRC_MATCH;
      end else if (pend[2]) begin
        grant_src = SRC_KEY;
      end
    end
  end

  always_comb begin
    hp_sel  = '0;
    dur_sel = '0;
    case (grant_src)
      SRC_HALT:  begin hp_sel = HP_HALT;  dur_sel = DUR_HALT;  end
      SRC_MATCH: begin hp_sel = HP_MATCH; dur_sel = DUR_MATCH; end
      SRC_KEY:   begin hp_sel = HP_KEY;   dur_sel = DUR_KEY;   end
      default:   begin hp_sel = '0;       dur_sel = '0;        end
    endcase
  end

  assign clr = {grant_src == SRC_KEY, grant_src == SRC_MATCH, grant_src == SRC_HALT};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_NONE;
      timer_q <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      hp_q    <= '0;
      dur_q   <= '0;
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_src != SRC_NONE) begin
            src_q   <= grant_src;
            hp_q    <= hp_sel;
            dur_q   <= dur_sel;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          timer_q <= dur_q - 24'd1;
          state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (timer_q == '0) begin
            timer_q <= GAP_M1;
            state_q <= ST_GAP;
          end else begin
            timer_q <= timer_q - 24'd1;
          end
        end
        ST_GAP: begin
          if (timer_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q - 24'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign drop_cnt_d = sat_add8(drop_cnt_q, {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign play_trigger = trig_q;
  assign half_period  = hp_q;
  assign duration     = dur_q;
  assign busy         = busy_q;
  assign active_src   = src_q;
  assign drop_count   = drop_cnt_q;

endmodule
